// File: rtl/servo_scan_sequencer.sv
// Mission sequencer for the magnet servo: period tick, settle/sweep/pick
// phases with watchdog timeouts into a sticky fault.
module servo_scan_sequencer #(
    parameter int PERIOD_CLKS       = 2_000_000,
    parameter int SETTLE_PERIODS    = 25,
    parameter int SWEEP_MAX_PERIODS = 600,
    parameter int PICK_MAX_PERIODS  = 200
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       detect,
    input  logic       servo_done,
    output logic       servo_enable,
    output logic [1:0] scanning,
    output logic       done_period,
    output logic       busy,
    output logic       complete,
    output logic       fault,
    output logic [2:0] state_dbg
);

    localparam int PW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CLKS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_PERIODS - 1);
    localparam logic [15:0] SWEEP_LAST  = 16'(SWEEP_MAX_PERIODS - 1);
    localparam logic [15:0] PICK_LAST   = 16'(PICK_MAX_PERIODS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SWEEP  = 3'd2,
        S_PICK   = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [PW-1:0] r_per_cnt;
    logic [15:0] r_phase;
    logic        r_done_period;
    logic        r_servo_enable;
    logic [1:0]  r_scanning;
    logic        r_busy;
    logic        r_complete;
    logic        r_fault;
    logic        w_settle_hit;
    logic        w_sweep_hit;
    logic        w_pick_hit;

    // Free-running period timer, never resynchronised to the mission
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_per_cnt     <= '0;
            r_done_period <= 1'b0;
        end else begin
            r_done_period <= (r_per_cnt == PER_LAST);
            if (r_per_cnt == PER_LAST)
                r_per_cnt <= '0;
            else
                r_per_cnt <= r_per_cnt + 1'b1;
        end
    end

    assign w_settle_hit = r_done_period && (r_phase == SETTLE_LAST);
    assign w_sweep_hit  = r_done_period && (r_phase == SWEEP_LAST);
    assign w_pick_hit   = r_done_period && (r_phase == PICK_LAST);

    always_ff @(posedge CLK) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_next = S_SETTLE;
                S_SETTLE: if (w_settle_hit) w_next = S_SWEEP;
                S_SWEEP: begin
                    if (detect)
                        w_next = S_PICK;
                    else if (w_sweep_hit)
                        w_next = S_FAULT;
                end
                S_PICK: begin
                    if (servo_done)
                        w_next = S_DONE;
                    else if (w_pick_hit)
                        w_next = S_FAULT;
                end
                S_DONE:   w_next = S_IDLE;
                S_FAULT:  w_next = S_FAULT;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Phase tick counter restarts on every state entry
    always_ff @(posedge CLK) begin
        if (reset)
            r_phase <= '0;
        else if (w_next != r_state)
            r_phase <= '0;
        else if (r_done_period && (r_phase != 16'hFFFF))
            r_phase <= r_phase + 16'd1;
    end

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_servo_enable <= 1'b0;
            r_scanning     <= 2'd0;
            r_busy         <= 1'b0;
            r_complete     <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_servo_enable <= (w_next == S_SETTLE) || (w_next == S_SWEEP) ||
                              (w_next == S_PICK);
            r_busy         <= (w_next == S_SETTLE) || (w_next == S_SWEEP) ||
                              (w_next == S_PICK);
            r_complete     <= (w_next == S_DONE);
            case (w_next)
                S_SWEEP: r_scanning <= 2'd1;
                S_PICK:  r_scanning <= 2'd2;
                default: r_scanning <= 2'd0;
            endcase
            if (w_next == S_FAULT)
                r_fault <= 1'b1;
            else if ((r_state == S_IDLE) && (w_next == S_SETTLE))
                r_fault <= 1'b0;
        end
    end

    assign servo_enable = r_servo_enable;
    assign scanning     = r_scanning;
    assign done_period  = r_done_period;
    assign busy         = r_busy;
    assign complete     = r_complete;
    assign fault        = r_fault;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_servo_scan_sequencer.sv
// Directed bench for servo_scan_sequencer with short periods.
module tb_servo_scan_sequencer;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       detect = 1'b0;
    logic       servo_done = 1'b0;
    logic       servo_enable;
    logic [1:0] scanning;
    logic       done_period;
    logic       busy;
    logic       complete;
    logic       fault;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    servo_scan_sequencer #(
        .PERIOD_CLKS      (10),
        .SETTLE_PERIODS   (2),
        .SWEEP_MAX_PERIODS(5),
        .PICK_MAX_PERIODS (4)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .detect      (detect),
        .servo_done  (servo_done),
        .servo_enable(servo_enable),
        .scanning    (scanning),
        .done_period (done_period),
        .busy        (busy),
        .complete    (complete),
        .fault       (fault),
        .state_dbg   (state_dbg)
    );

    always #5 CLK = ~CLK;

    // Advance to the next negedge where done_period is high
    task automatic wait_tick(input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (done_period) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s tick timeout: no done_period in 15 cycles, required one", tag);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            if (state_dbg == s) begin
                hit = 1;
                break;
            end
            @(negedge CLK);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s wait_state: state %0d, required %0d", tag, state_dbg, s);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({servo_enable, scanning, done_period, busy, complete, fault, state_dbg} !== 10'd0) begin
            errors++;
            $display("FAIL reset_state: outputs %b, required all zero",
                     {servo_enable, scanning, done_period, busy, complete, fault, state_dbg});
        end
    endtask

    task automatic test_period_tick();
        int pulses;
        int first;
        int last;
        int prev;
        bit bad_gap;
        pulses = 0;
        first = -1;
        last = -1;
        prev = 0;
        bad_gap = 0;
        reset = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge CLK);
            if (done_period) begin
                pulses++;
                if (first < 0) first = n;
                if (last >= 0 && (n - last) != 10) bad_gap = 1;
                if (prev) bad_gap = 1;
                last = n;
            end
            prev = done_period;
        end
        checks++;
        if (pulses !== 5) begin
            errors++;
            $display("FAIL period_count: %0d pulses, required 5", pulses);
        end
        checks++;
        if (first !== 10) begin
            errors++;
            $display("FAIL period_first: first pulse at cycle %0d, required 10", first);
        end
        checks++;
        if (bad_gap !== 1'b0) begin
            errors++;
            $display("FAIL period_spacing: bad gap/width flag %0d, required 0", bad_gap);
        end
    endtask

    task automatic test_nominal();
        pulse_start();
        checks++;
        if ({state_dbg, servo_enable, scanning, busy} !== {3'd1, 1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL nom_settle: st %0d en %0d scan %0d busy %0d, required 1 1 0 1",
                     state_dbg, servo_enable, scanning, busy);
        end
        wait_state(3'd2, "nom_sweep");
        checks++;
        if (scanning !== 2'd1) begin
            errors++;
            $display("FAIL nom_scan1: scanning %0d, required 1", scanning);
        end
        repeat (3) wait_tick("nom_sweep_tick");
        detect = 1'b1;
        @(negedge CLK);
        detect = 1'b0;
        checks++;
        if ({state_dbg, scanning, servo_enable} !== {3'd3, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL nom_pick: st %0d scan %0d en %0d, required 3 2 1",
                     state_dbg, scanning, servo_enable);
        end
        repeat (2) wait_tick("nom_pick_tick");
        servo_done = 1'b1;
        @(negedge CLK);
        servo_done = 1'b0;
        checks++;
        if ({state_dbg, complete, servo_enable, busy, scanning} !== {3'd4, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL nom_done: st %0d cmp %0d en %0d busy %0d scan %0d, required 4 1 0 0 0",
                     state_dbg, complete, servo_enable, busy, scanning);
        end
        @(negedge CLK);
        checks++;
        if ({state_dbg, complete, busy, fault} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL nom_idle: st %0d cmp %0d busy %0d fault %0d, required 0 0 0 0",
                     state_dbg, complete, busy, fault);
        end
    endtask

    task automatic test_sweep_timeout();
        pulse_start();
        wait_state(3'd2, "to_sweep");
        repeat (4) wait_tick("to_tick");
        checks++;
        if (state_dbg !== 3'd2) begin
            errors++;
            $display("FAIL to_early: st %0d after 4 ticks, required 2", state_dbg);
        end
        wait_tick("to_tick5");
        @(negedge CLK);
        checks++;
        if ({state_dbg, fault, servo_enable, busy} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL to_fault: st %0d fault %0d en %0d busy %0d, required 5 1 0 0",
                     state_dbg, fault, servo_enable, busy);
        end
        pulse_start();
        checks++;
        if ({state_dbg, fault} !== {3'd5, 1'b1}) begin
            errors++;
            $display("FAIL to_start_ign: st %0d fault %0d, required 5 1", state_dbg, fault);
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checks++;
        if ({state_dbg, fault} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL to_abort: st %0d fault %0d, required 0 1", state_dbg, fault);
        end
        pulse_start();
        checks++;
        if ({state_dbg, fault} !== {3'd1, 1'b0}) begin
            errors++;
            $display("FAIL to_restart: st %0d fault %0d, required 1 0", state_dbg, fault);
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
    endtask

    task automatic test_coincident();
        pulse_start();
        wait_state(3'd2, "co_sweep");
        repeat (5) wait_tick("co_sweep_tick");
        detect = 1'b1;
        @(negedge CLK);
        detect = 1'b0;
        checks++;
        if ({state_dbg, fault} !== {3'd3, 1'b0}) begin
            errors++;
            $display("FAIL co_detect_wins: st %0d fault %0d, required 3 0", state_dbg, fault);
        end
        repeat (4) wait_tick("co_pick_tick");
        servo_done = 1'b1;
        @(negedge CLK);
        servo_done = 1'b0;
        checks++;
        if ({state_dbg, complete, fault} !== {3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL co_done_wins: st %0d cmp %0d fault %0d, required 4 1 0",
                     state_dbg, complete, fault);
        end
        @(negedge CLK);
    endtask

    task automatic test_abort_priority();
        pulse_start();
        wait_state(3'd2, "ab_sweep");
        wait_tick("ab_tick");
        detect = 1'b1;
        @(negedge CLK);
        detect = 1'b0;
        checks++;
        if (state_dbg !== 3'd3) begin
            errors++;
            $display("FAIL ab_pick: st %0d, required 3", state_dbg);
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checks++;
        if ({state_dbg, servo_enable, scanning} !== {3'd0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL ab_pick_abort: st %0d en %0d scan %0d, required 0 0 0",
                     state_dbg, servo_enable, scanning);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({state_dbg, servo_enable} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL ab_start_abort: st %0d en %0d, required 0 0", state_dbg, servo_enable);
        end
        pulse_start();
        wait_state(3'd2, "ab_sweep2");
        pulse_start();
        checks++;
        if ({state_dbg, scanning} !== {3'd2, 2'd1}) begin
            errors++;
            $display("FAIL ab_start_sweep: st %0d scan %0d, required 2 1", state_dbg, scanning);
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        pulse_start();
        wait_state(3'd2, "rs_sweep");
        reset = 1'b1;
        @(negedge CLK);
        checks++;
        if ({servo_enable, scanning, done_period, busy, complete, fault, state_dbg} !== 10'd0) begin
            errors++;
            $display("FAIL rs_outputs: outputs %b, required all zero",
                     {servo_enable, scanning, done_period, busy, complete, fault, state_dbg});
        end
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (done_period) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL rs_period: first tick after %0d cycles, required 10", n);
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_period_tick();
        test_nominal();
        test_sweep_timeout();
        test_coincident();
        test_abort_priority();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_scan_sequencer.md
Name: servo_scan_sequencer

Overview:
- Top-level sequencer for the magnet servo stepper datapath. Generates the servo period tick (done_period), drives its enable and scanning mode, and sequences one mission: settle at middle, sweep until metal detect, then pick/return until the servo reports done.
- Watchdog timeouts abort a stuck phase into a sticky fault state. Sits between the mission FSM (start/abort) and the servo stepper plus PWM block.

Parameters:
- PERIOD_CLKS, 2_000_000, clocks per servo period (20 ms at 100 MHz); done_period pulses once per period.
- SETTLE_PERIODS, 25, periods held at middle (scanning=0) before the sweep starts.
- SWEEP_MAX_PERIODS, 600, sweep timeout in periods.
- PICK_MAX_PERIODS, 200, pick/return timeout in periods.

Ports:
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle mission request; honoured only in IDLE
- abort  in  1  return to IDLE from any state
- detect  in  1  synchronised metal-detect level; sampled only in SWEEP
- servo_done  in  1  done flag from the servo stepper; honoured only in PICK
- servo_enable  out  1  enable to the servo stepper
- scanning  out  2  servo mode: 0 hold, 1 sweep, 2 pick/return
- done_period  out  1  one-cycle period tick to the servo stepper
- busy  out  1  high in SETTLE, SWEEP and PICK
- complete  out  1  one-cycle pulse on successful mission end
- fault  out  1  sticky timeout flag
- state_dbg  out  3  current state encoding

Behaviour:
- All outputs are registered.
- Reset values: servo_enable=0, scanning=0, done_period=0, busy=0, complete=0, fault=0, state=IDLE, all counters 0.
- Period timer:
  - Free-running counter 0..PERIOD_CLKS-1, independent of state. It wraps to 0 and is cleared only by reset.
  - done_period=1 in the cycle after the counter equals PERIOD_CLKS-1; otherwise 0.
  - Counter width is $clog2(PERIOD_CLKS).
- Phase counter: 16-bit count of done_period ticks in the current state. Cleared on every state entry, saturates at 0xFFFF.
- States (state_dbg): IDLE=0, SETTLE=1, SWEEP=2, PICK=3, DONE=4, FAULT=5.
- IDLE: servo_enable=0, scanning=0.
  - start=1 and abort=0 -> SETTLE next cycle, so servo_enable=1 one cycle after start.
  - fault is cleared on that transition.
- SETTLE: servo_enable=1, scanning=0.
  - The tick that brings the phase count to SETTLE_PERIODS -> SWEEP.
- SWEEP: servo_enable=1, scanning=1.
  - detect=1 -> PICK.
  - Otherwise, the tick reaching SWEEP_MAX_PERIODS -> FAULT.
  - If detect and the timeout tick occur in the same cycle, detect wins.
- PICK: servo_enable=1, scanning=2.
  - servo_done=1 -> DONE.
  - Otherwise, the tick reaching PICK_MAX_PERIODS -> FAULT.
  - servo_done wins over a coincident timeout.
- DONE: one cycle only. complete=1, servo_enable=0 (which clears the stepper's done), scanning=0. Next state is IDLE.
- FAULT: servo_enable=0, scanning=0, fault=1.
  - Stays in FAULT until abort -> IDLE; fault remains 1 after this exit.
  - start is ignored in FAULT.
  - fault clears only on the next accepted start, or on reset.
- abort: from any state other than IDLE, the next state is IDLE and servo_enable=0 the following cycle. abort has priority over all other transitions, and over start in IDLE.
- start outside IDLE: ignored, no queuing.
- detect and servo_done outside their states: ignored, no latching.
- The period timer is not resynchronised on start, so the first settle tick may arrive after fewer than PERIOD_CLKS cycles. The settle time is therefore between SETTLE_PERIODS-1 and SETTLE_PERIODS periods.
- Reset mid-mission: all outputs return to reset values on the next edge; the servo stepper re-centres because enable drops.

Test Plan:
Bench parameters: PERIOD_CLKS=10, SETTLE_PERIODS=2, SWEEP_MAX_PERIODS=5, PICK_MAX_PERIODS=4.
- Period tick: run reset-free for 50 cycles -> done_period pulses every 10th cycle, exactly 1 cycle wide, 5 pulses.
- Nominal mission: start, then detect at the 3rd sweep tick, servo_done after 2 pick ticks -> scanning sequence 0,1,2. complete is a single pulse; servo_enable falls in the DONE cycle; busy is low after it; fault=0.
- Sweep timeout: start, no detect -> FAULT on the 5th sweep tick with fault=1 and servo_enable=0. A following start is ignored. abort -> IDLE with fault still 1. A new start clears fault.
- Coincident events: detect asserted in the same cycle as the 5th sweep tick -> PICK, not FAULT. servo_done with the 4th pick tick -> DONE.
- Abort/priority: abort during PICK -> IDLE next cycle, servo_enable=0. start+abort together in IDLE -> stays IDLE. start during SWEEP -> no effect.
- Reset mid-SWEEP: reset for 1 cycle -> all outputs 0 and state_dbg=0 on the next edge; the period counter restarts, so the next done_period comes 10 cycles after reset is released.
